// File: rtl/sd_sec_write.sv
// rtl/sd_sec_write.sv - single-block SD-card sector write engine (SPI mode, CMD24)
//
// Purpose:
//   Accepts a sector-write request from the image-save controller. The engine
//   issues CMD24 and streams 256 16-bit FIFO words as one 512-byte data block.
//   It then waits for the card to finish programming and reports completion.
//   SPI mode 0. Bytes go out MSB first, and consecutive bytes are sent
//   back-to-back with no idle cycles.
//
// Configuration macro:
//   SD_WR_SDSC_BYTE_ADDR_EN
//     - Defined: the CMD24 argument is wr_sec_addr << 9 (byte addressing, SDSC).
//     - Undefined: the CMD24 argument is wr_sec_addr (block addressing, SDHC/SDXC).
//
// Parameters:
//   SCK_DIV   SCK half-period in clk cycles (>= 1)
//   NCR_MAX   max bytes polled for R1 before error
//   BUSY_MAX  max bytes polled for busy release before error (<= 65536)
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sd_init_done    card initialized; gates acceptance of new starts
//   wr_start_en     start request (sampled in IDLE only)
//   wr_sec_addr     sector address, latched on accepted start
//   wr_busy         high from accept through the DONE cycle
//   wr_req          one-cycle FIFO read strobe per word
//   wr_data         FIFO word, valid the cycle after wr_req
//   wr_block_wdone  one-cycle completion pulse
//   wr_err          error flag, coincident with wr_block_wdone
//   sd_cs, sd_sck, sd_mosi, sd_miso   SPI pins
`timescale 1ns/1ps

module sd_sec_write #(
  parameter int SCK_DIV  = 2,
  parameter int NCR_MAX  = 8,
  parameter int BUSY_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        wr_start_en,
  input  logic [31:0] wr_sec_addr,
  output logic        wr_busy,
  output logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_block_wdone,
  output logic        wr_err,
  output logic        sd_cs,
  output logic        sd_sck,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int CNT_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_CMD,
    S_R1,
    S_GAP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_DRESP,
    S_BUSY,
    S_POST,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        arg_q, arg_d;
  logic               err_flag_q, err_flag_d;
  logic               busy_q, busy_d;
  logic               cs_q, cs_d;
  logic               req_q, req_d;
  logic               wdone_q, wdone_d;
  logic               werr_q, werr_d;
  logic [7:0]         lo_q, lo_d;
  logic [15:0]        buf_q;
  logic               cap_q;

  // Byte engine state
  logic               act_q;
  logic [DIV_W-1:0]   div_q;
  logic               half_q;
  logic [2:0]         bit_q;
  logic [7:0]         tx_q;
  logic [7:0]         rx_q;
  logic               sck_q;
  logic               mosi_q;

  logic               start_byte;
  logic [7:0]         start_val;
  logic               byte_done;
  logic [CNT_W-1:0]   next_idx;
  logic [31:0]        addr_arg;

`ifdef SD_WR_SDSC_BYTE_ADDR_EN
  assign addr_arg = wr_sec_addr << 9;
`else
  assign addr_arg = wr_sec_addr;
`endif

  // Last cycle of the high half of bit 7. The received byte is complete in
  // rx_q here, and a byte started in this cycle follows with no gap.
  assign byte_done = act_q && half_q && (div_q == DIV_LAST) && (bit_q == 3'd7);
  assign next_idx  = cnt_q + 16'd1;

  function automatic logic [7:0] cmd_byte(input logic [CNT_W-1:0] idx,
                                          input logic [31:0] arg);
    case (idx)
      16'd1:   cmd_byte = arg[31:24];
      16'd2:   cmd_byte = arg[23:16];
      16'd3:   cmd_byte = arg[15:8];
      16'd4:   cmd_byte = arg[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      arg_q      <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      req_q      <= 1'b0;
      wdone_q    <= 1'b0;
      werr_q     <= 1'b0;
      lo_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arg_q      <= arg_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      req_q      <= req_d;
      wdone_q    <= wdone_d;
      werr_q     <= werr_d;
      lo_q       <= lo_d;
    end
  end

  // The word requested with req_q is on wr_data one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= 1'b0;
      buf_q <= 16'h0000;
    end else begin
      cap_q <= req_q;
      if (cap_q) begin
        buf_q <= wr_data;
      end
    end
  end

  // State transitions happen only on byte_done, so the next state's first byte
  // is loaded in the same cycle the previous byte ends.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arg_d      = arg_q;
    err_flag_d = err_flag_q;
    busy_d     = busy_q;
    cs_d       = cs_q;
    req_d      = 1'b0;
    wdone_d    = 1'b0;
    werr_d     = 1'b0;
    lo_d       = lo_q;
    start_byte = 1'b0;
    start_val  = 8'hFF;

    case (state_q)
      S_IDLE: begin
        if (wr_start_en && sd_init_done) begin
          arg_d      = addr_arg;
          busy_d     = 1'b1;
          cs_d       = 1'b0;
          state_d    = S_PRE;
          start_byte = 1'b1;
        end
      end

      S_PRE: begin
        if (byte_done) begin
          state_d    = S_CMD;
          cnt_d      = '0;
          start_byte = 1'b1;
          start_val  = 8'h58;
        end
      end

      S_CMD: begin
        if (byte_done) begin
          start_byte = 1'b1;
          if (cnt_q == 16'd5) begin
            state_d = S_R1;
            cnt_d   = '0;
          end else begin
            cnt_d     = next_idx;
            start_val = cmd_byte(next_idx, arg_q);
          end
        end
      end

      S_R1: begin
        if (byte_done) begin
          start_byte = 1'b1;
          if (!rx_q[7]) begin
            if (rx_q == 8'h00) begin
              state_d = S_GAP;
            end else begin
              err_flag_d = 1'b1;
              cs_d       = 1'b1;
              state_d    = S_POST;
            end
          end else if (cnt_q == CNT_W'(NCR_MAX - 1)) begin
            err_flag_d = 1'b1;
            cs_d       = 1'b1;
            state_d    = S_POST;
          end else begin
            cnt_d = next_idx;
          end
        end
      end

      // Word 0 is requested at the token's start and word 1 at the first data
      // byte. After that, each high byte fetches the following word. Every
      // request is therefore at least one byte time ahead of its use.
      S_GAP: begin
        if (byte_done) begin
          state_d    = S_TOKEN;
          start_byte = 1'b1;
          start_val  = 8'hFE;
          req_d      = 1'b1;
        end
      end

      S_TOKEN: begin
        if (byte_done) begin
          state_d    = S_DATA;
          cnt_d      = '0;
          start_byte = 1'b1;
          start_val  = buf_q[15:8];
          lo_d       = buf_q[7:0];
          req_d      = 1'b1;
        end
      end

      S_DATA: begin
        if (byte_done) begin
          start_byte = 1'b1;
          if (cnt_q == 16'd511) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = next_idx;
            if (next_idx[0]) begin
              start_val = lo_q;
            end else begin
              // lo_q holds the low byte because buf_q is refilled mid-word.
              start_val = buf_q[15:8];
              lo_d      = buf_q[7:0];
              req_d     = (next_idx <= 16'd508);
            end
          end
        end
      end

      S_CRC: begin
        if (byte_done) begin
          start_byte = 1'b1;
          if (cnt_q == 16'd1) begin
            state_d = S_DRESP;
          end else begin
            cnt_d = 16'd1;
          end
        end
      end

      S_DRESP: begin
        if (byte_done) begin
          if (rx_q[4:0] != 5'b00101) begin
            err_flag_d = 1'b1;
          end
          state_d    = S_BUSY;
          cnt_d      = '0;
          start_byte = 1'b1;
        end
      end

      S_BUSY: begin
        if (byte_done) begin
          start_byte = 1'b1;
          if (rx_q != 8'h00) begin
            cs_d    = 1'b1;
            state_d = S_POST;
          end else if (cnt_q == CNT_W'(BUSY_MAX - 1)) begin
            err_flag_d = 1'b1;
            cs_d       = 1'b1;
            state_d    = S_POST;
          end else begin
            cnt_d = next_idx;
          end
        end
      end

      S_POST: begin
        if (byte_done) begin
          state_d = S_DONE;
          wdone_d = 1'b1;
          werr_d  = err_flag_q;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        err_flag_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SPI byte shifter, mode 0. Each bit is SCK_DIV cycles with SCK low, then
  // SCK_DIV cycles with SCK high. MISO is captured as SCK rises, and MOSI
  // advances as SCK falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= 1'b0;
      div_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= 3'd0;
      tx_q   <= 8'hFF;
      rx_q   <= 8'hFF;
      sck_q  <= 1'b0;
      mosi_q <= 1'b1;
    end else if (start_byte) begin
      act_q  <= 1'b1;
      div_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= 3'd0;
      tx_q   <= start_val;
      mosi_q <= start_val[7];
      sck_q  <= 1'b0;
    end else if (act_q) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (!half_q) begin
          sck_q  <= 1'b1;
          half_q <= 1'b1;
          rx_q   <= {rx_q[6:0], sd_miso};
        end else begin
          sck_q  <= 1'b0;
          half_q <= 1'b0;
          if (bit_q == 3'd7) begin
            act_q  <= 1'b0;
            mosi_q <= 1'b1;
          end else begin
            bit_q  <= bit_q + 3'd1;
            tx_q   <= {tx_q[6:0], 1'b1};
            mosi_q <= tx_q[6];
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign wr_busy        = busy_q;
  assign wr_req         = req_q;
  assign wr_block_wdone = wdone_q;
  assign wr_err         = werr_q;
  assign sd_cs          = cs_q;
  assign sd_sck         = sck_q;
  assign sd_mosi        = mosi_q;

endmodule

// File: tb/tb_sd_sec_write.sv
// tb/tb_sd_sec_write.sv - self-checking bench for sd_sec_write with an SPI card model and FIFO model
`timescale 1ns/1ps

module tb_sd_sec_write;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_init_done = 1'b0;
  logic        wr_start_en = 1'b0;
  logic [31:0] wr_sec_addr = 32'h0;
  logic [15:0] wr_data = 16'h0;
  logic        sd_miso = 1'b1;
  logic        wr_busy, wr_req, wr_block_wdone, wr_err;
  logic        sd_cs, sd_sck, sd_mosi;

  sd_sec_write #(.SCK_DIV(1), .NCR_MAX(8), .BUSY_MAX(65535)) dut (
    .clk(clk), .rst(rst), .sd_init_done(sd_init_done),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr),
    .wr_busy(wr_busy), .wr_req(wr_req), .wr_data(wr_data),
    .wr_block_wdone(wr_block_wdone), .wr_err(wr_err),
    .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  r1;
    logic [7:0]  dresp;
    int          busy_n;
    logic [15:0] base;
    logic        exp_err;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic        err;
    int          req;
    logic [47:0] frame;
  } exp_t;

  exp_t exp_q[$];

  // Card and FIFO behaviour for the current block
  logic [7:0]  c_r1 = 8'h00;
  logic [7:0]  c_dresp = 8'hE5;
  int          c_busy_n = 0;
  logic [15:0] f_base = 16'h0;
  logic        clr = 1'b0;

  // FIFO model: the word appears on wr_data the cycle after wr_req
  int req_cnt = 0;
  int fifo_idx = 0;
  int wd_cnt = 0;
  always @(posedge clk) begin
    if (clr) begin
      req_cnt  <= 0;
      fifo_idx <= 0;
      wd_cnt   <= 0;
    end else begin
      if (wr_req) begin
        wr_data  <= f_base + 16'(fifo_idx);
        fifo_idx <= fifo_idx + 1;
        req_cnt  <= req_cnt + 1;
      end
      if (wr_block_wdone) wd_cnt <= wd_cnt + 1;
    end
  end

  // SD card model, evaluated between clk edges: samples MOSI after SCK rises, drives MISO after SCK falls
  localparam int C_IDLE = 0, C_CMD = 1, C_TOK = 2, C_DATA = 3, C_CRC = 4, C_BUSY = 5;
  logic        sck_prev = 1'b0;
  int          rbits = 0;
  logic [7:0]  rxsh = 8'h0;
  logic [7:0]  cur_out = 8'hFF;
  logic [7:0]  cb, cexp;
  logic [15:0] cw;
  int          cst = C_IDLE;
  int          cidx = 0, didx = 0, cc = 0, bcnt = 0;
  logic [47:0] frame = 48'h0;
  logic [47:0] cmd_log = 48'h0;
  int          cmd_cnt = 0, data_bytes = 0, data_bad = 0;

  always @(negedge clk) begin
    if (clr) begin
      cmd_cnt = 0; data_bytes = 0; data_bad = 0; cmd_log = 48'h0;
    end
    if (sd_cs) begin
      rbits = 0; cur_out = 8'hFF; sd_miso = 1'b1; cst = C_IDLE;
    end else if (sd_sck && !sck_prev) begin
      cb = {rxsh[6:0], sd_mosi};
      rxsh = cb;
      rbits++;
      if (rbits == 8) begin
        rbits = 0;
        cur_out = 8'hFF;
        case (cst)
          C_IDLE: if (cb == 8'h58) begin frame = {40'h0, cb}; cidx = 1; cst = C_CMD; end
          C_CMD: begin
            frame = {frame[39:0], cb};
            cidx++;
            if (cidx == 6) begin
              cmd_log = frame; cmd_cnt++;
              cur_out = c_r1;
              cst = (c_r1 == 8'h00) ? C_TOK : C_IDLE;
            end
          end
          C_TOK: if (cb == 8'hFE) begin cst = C_DATA; didx = 0; end
          C_DATA: begin
            cw = f_base + 16'(didx / 2);
            cexp = (didx % 2 == 1) ? cw[7:0] : cw[15:8];
            if (cb != cexp) data_bad++;
            data_bytes++;
            didx++;
            if (didx == 512) begin cst = C_CRC; cc = 0; end
          end
          C_CRC: begin
            cc++;
            if (cc == 2) begin cur_out = c_dresp; cst = C_BUSY; bcnt = 0; end
          end
          C_BUSY: begin
            if (bcnt < c_busy_n) begin cur_out = 8'h00; bcnt++; end
            else cst = C_IDLE;
          end
          default: cst = C_IDLE;
        endcase
      end
    end else if (!sd_sck && sck_prev) begin
      sd_miso = cur_out[3'(7 - rbits)];
    end
    sck_prev = sd_sck;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] exp_arg(input logic [31:0] a);
`ifdef SD_WR_SDSC_BYTE_ADDR_EN
    return a << 9;
`else
    return a;
`endif
  endfunction

  task automatic chk_reset_outs(input string nm);
    chk(nm, {57'h0, sd_cs, sd_sck, sd_mosi, wr_busy, wr_req, wr_block_wdone, wr_err},
        {57'h0, 7'b1010000});
  endtask

  task automatic setup(input vec_t v);
    c_r1 = v.r1; c_dresp = v.dresp; c_busy_n = v.busy_n; f_base = v.base;
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic start_blk(input vec_t v);
    exp_t e;
    e.err = v.exp_err;
    e.req = v.exp_req;
    e.frame = {8'h58, exp_arg(v.addr), 8'hFF};
    @(negedge clk); #1;
    wr_sec_addr = v.addr;
    wr_start_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    wr_start_en = 1'b0;
    chk("start_busy_cs", {62'h0, wr_busy, sd_cs}, {62'h0, 2'b10});
  endtask

  task automatic wait_req(input int n);
    int k;
    for (k = 0; k < 10000 && req_cnt < n; k++) @(negedge clk);
    if (req_cnt < n) chk("req_wait_timeout", 64'(req_cnt), 64'(n));
  endtask

  task automatic finish_blk(input string nm);
    exp_t e;
    int k;
    for (k = 0; k < 20000 && !wr_block_wdone; k++) @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({nm, "_no_expect"}, 64'd0, 64'd1);
    end else if (!wr_block_wdone) begin
      void'(exp_q.pop_front());
      chk({nm, "_wdone_timeout"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_err"}, {63'h0, wr_err}, {63'h0, e.err});
      chk({nm, "_cs_high"}, {63'h0, sd_cs}, 64'd1);
      @(negedge clk);
      chk({nm, "_busy_low_wdone_low"}, {62'h0, wr_busy, wr_block_wdone}, 64'd0);
      chk({nm, "_req_count"}, 64'(req_cnt), 64'(e.req));
      chk({nm, "_wdone_count"}, 64'(wd_cnt), 64'd1);
      chk({nm, "_cmd_count"}, 64'(cmd_cnt), 64'd1);
      chk({nm, "_cmd_frame"}, {16'h0, cmd_log}, {16'h0, e.frame});
      if (e.req == 256) begin
        chk({nm, "_data_bytes"}, 64'(data_bytes), 64'd512);
        chk({nm, "_data_bad"}, 64'(data_bad), 64'd0);
      end
    end
  endtask

  vec_t vecs[5];
  vec_t v;

  initial begin
    vecs[0] = '{32'd10,         8'h00, 8'hE5, 3, 16'h0000, 1'b0, 256};
    vecs[1] = '{32'h1234_5678,  8'h04, 8'hE5, 1, 16'h0000, 1'b1, 0};
    vecs[2] = '{32'd7,          8'h00, 8'hEB, 2, 16'h0100, 1'b1, 256};
    vecs[3] = '{32'hFFFF_FFFF,  8'hFF, 8'hE5, 1, 16'h0000, 1'b1, 0};
    vecs[4] = '{32'h8000_0001,  8'h00, 8'h05, 0, 16'hA55A, 1'b0, 256};

    repeat (4) @(posedge clk);
    #1 chk_reset_outs("reset_values");
    @(negedge clk);
    sd_init_done = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("idle_after_reset");

    for (int i = 0; i < 5; i++) begin
      setup(vecs[i]);
      start_blk(vecs[i]);
      finish_blk($sformatf("vec%0d", i));
    end

    // Start pulses ignored while busy; sd_init_done falling mid-block ignored
    v = '{32'h55, 8'h00, 8'hE5, 1, 16'h0200, 1'b0, 256};
    setup(v);
    start_blk(v);
    wait_req(50);
    @(negedge clk); #1;
    wr_sec_addr = 32'hAAAA_AAAA;
    wr_start_en = 1'b1;
    @(negedge clk); #1;
    wr_start_en = 1'b0;
    wait_req(150);
    sd_init_done = 1'b0;
    finish_blk("ign_busy");
    @(negedge clk); #1;
    wr_start_en = 1'b1;
    @(negedge clk); #1;
    wr_start_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("ign_noinit_idle", {62'h0, wr_busy, sd_cs}, {62'h0, 2'b01});
    chk("ign_noinit_cmd_count", 64'(cmd_cnt), 64'd1);
    sd_init_done = 1'b1;

    // Reset mid-DATA after 100 words, then a normal block
    v = '{32'h99, 8'h00, 8'hE5, 1, 16'h0000, 1'b0, 256};
    setup(v);
    start_blk(v);
    wait_req(100);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("reset_mid_data");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("reset_no_wdone", 64'(wd_cnt), 64'd0);
    chk_reset_outs("reset_idle_after");
    v = '{32'd33472, 8'h00, 8'hE5, 1, 16'h0300, 1'b0, 256};
    setup(v);
    start_blk(v);
    finish_blk("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
